batcharger_ctrl: RTL and testbench
==================================

// Module: batcharger_ctrl
// PURPOSE
//  Digital charge-mode controller that drives the battery charger analog front-end.
//  Consumes ADC-quantised battery voltage and current samples plus a temperature-OK flag.
//  Produces the one-hot mode selects (tc, cc, cv) that the charger uses to pick trickle,
//  constant-current or constant-voltage forcing. Also raises done at end of charge.
//  Sits directly upstream of the charger core; its tc/cc/cv outputs are the mode inputs the charger bench checks.
// PARAMETERS
//  W    8   ADC sample and threshold width (bits, unsigned)
//  DEB  4   consecutive qualifying samples required before any threshold-driven transition (1..15)
//  TW   16  CV safety-timer width (bits)
// PORTS
//  clk       in   1   system clock; all logic on rising edge
//  rstz      in   1   asynchronous active-low reset
//  en        in   1   charger enable (level)
//  vtok      in   1   battery temperature within limits (level)
//  smpl      in   1   1-cycle strobe; vbat/ibat valid only when high
//  vbat      in   W   battery voltage ADC code
//  ibat      in   W   battery current ADC code
//  vcutoff   in   W   TC->CC threshold: vbat >= vcutoff
//  vpreset   in   W   CC->CV threshold: vbat >= vpreset
//  iend      in   W   CV end-of-charge threshold: ibat <= iend
//  vrestart  in   W   END->TC recharge threshold: vbat < vrestart
//  tmax      in   TW  CV max duration in clk cycles; 0 disables the timer
//  tc        out  1   trickle-current mode select
//  cc        out  1   constant-current mode select
//  cv        out  1   constant-voltage mode select
//  done      out  1   charge complete
//  st        out  3   state code: IDLE=0 TC=1 CC=2 CV=3 END=4
// BEHAVIOUR
//  - Reset (rstz=0, async): state IDLE; tc=cc=cv=done=0; st=0; debounce and CV timer cleared.
//  - All outputs registered and decoded from state. tc/cc/cv/done are mutually exclusive; all are 0 in IDLE.
//  - Abort: if en=0 or vtok=0 on a clock edge, next state is IDLE from any state. Abort overrides every other transition.
//  - IDLE -> TC when en=1 and vtok=1 (1 cycle). Start is always in TC; no sample is needed.
//  - Per-state qualifier, evaluated only when smpl=1, all compares unsigned:
//      TC: vbat >= vcutoff
//      CC: vbat >= vpreset
//      CV: ibat <= iend
//      END: vbat < vrestart
//  - Debounce counter (0..DEB, saturating):
//      smpl=1 and qualifier true: +1
//      smpl=1 and qualifier false: cleared to 0
//      smpl=0: hold
//      cleared on every state change, including abort
//  - Threshold transitions (TC->CC, CC->CV, CV->END, END->TC) fire on the edge that samples
//    the DEB-th consecutive qualifying smpl. New mode is visible on outputs in the following cycle.
//  - CV timer:
//      cleared on CV entry; increments every clk while in CV; saturates at 2^TW-1
//      tmax != 0 and timer == tmax-1 on an edge: CV->END, so exactly tmax cycles are spent in CV
//      timer expiry and current qualifier completing in the same cycle: both give END (no conflict)
//  - A smpl that arrives on the same edge as a state change is discarded; the counter starts from 0 in the new state.
//  - Threshold inputs are sampled live and may change at any time; no latching.
//  - No other transitions exist. Illegal state encodings recover to IDLE.
// TESTING
//  - DEB=4, vcutoff=0x60: hold en=vtok=1 and pulse smpl every 10 clk with vbat=0x61
//      -> tc=1 after IDLE; cc=1 one cycle after the 4th sample's edge
//  - TC with sample sequence vbat=0x61,0x61,0x61,0x5F,0x61,0x61,0x61 -> stays tc (counter cleared by 0x5F); a further 0x61 -> cc
//  - CC, vpreset=0xC0, four samples of vbat=0xC0 -> cv=1; then iend=0x10, four samples of ibat=0x0F -> done=1, st=4
//  - CV, tmax=100, ibat=0x80 held -> done=1 exactly 100 clk after cv rose; tmax=0 -> cv held indefinitely
//  - In CV drop vtok for 1 cycle -> st=0, all outputs 0 next cycle; vtok back -> tc
//  - In END, four samples of vbat < vrestart -> tc; assert rstz=0 mid-CC -> outputs 0 immediately, without waiting for clk

Source files
------------

// File: rtl/batcharger_ctrl.sv
// -----------------------------------------------------------------------------
// batcharger_ctrl
// Charge-mode sequencer for the battery charger analog front-end.
// Walks IDLE -> TC -> CC -> CV -> END (and END -> TC on recharge) using
// debounced, strobe-qualified ADC comparisons plus a CV safety timer.
// The mode selects tc/cc/cv, done and the state code st are registered and
// decoded from the next state, so they always match the registered state.
// -----------------------------------------------------------------------------
module batcharger_ctrl #(
    parameter int W   = 8,
    parameter int DEB = 4,
    parameter int TW  = 16
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic          en,
    input  logic          vtok,
    input  logic          smpl,
    input  logic [W-1:0]  vbat,
    input  logic [W-1:0]  ibat,
    input  logic [W-1:0]  vcutoff,
    input  logic [W-1:0]  vpreset,
    input  logic [W-1:0]  iend,
    input  logic [W-1:0]  vrestart,
    input  logic [TW-1:0] tmax,
    output logic          tc,
    output logic          cc,
    output logic          cv,
    output logic          done,
    output logic [2:0]    st
);

    // State codes double as the externally visible st value.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TC   = 3'd1,
        S_CC   = 3'd2,
        S_CV   = 3'd3,
        S_END  = 3'd4
    } state_t;

    // Debounce counter is sized for the full 1..15 range of DEB.
    localparam int            CW      = 4;
    localparam logic [CW-1:0] DEB_C   = CW'(DEB);
    localparam logic [CW-1:0] DEB_M1  = CW'(DEB - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMR_ONE = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMR_MAX = {TW{1'b1}};

    state_t        state_q, state_d;
    logic [CW-1:0] deb_q, deb_d;
    logic [TW-1:0] tmr_q, tmr_d;

    logic          tc_q, tc_d;
    logic          cc_q, cc_d;
    logic          cv_q, cv_d;
    logic          done_q, done_d;
    logic [2:0]    st_q, st_d;

    logic          abort_s;
    logic          qual_s;
    logic          deb_hit_s;
    logic [TW-1:0] tmax_m1_s;
    logic          tmr_exp_s;
    logic          state_chg_s;

    // Loss of enable or temperature window forces IDLE from anywhere.
    assign abort_s = (~en) | (~vtok);

    // The sample completing the debounce run is the DEB-th consecutive hit.
    assign deb_hit_s = smpl & qual_s & (deb_q >= DEB_M1);

    // CV timer expiry: the timer counts cycles already spent in CV, so
    // matching tmax-1 on an edge means this edge ends the tmax-th cycle.
    assign tmax_m1_s = tmax - TMR_ONE;
    assign tmr_exp_s = (state_q == S_CV) && (tmax != {TW{1'b0}}) && (tmr_q == tmax_m1_s);

    assign state_chg_s = (state_d != state_q);

    // Select the per-state qualifier; compares are unsigned and use live thresholds.
    always_comb begin
        qual_s = 1'b0;
        case (state_q)
            S_TC:    qual_s = (vbat >= vcutoff);
            S_CC:    qual_s = (vbat >= vpreset);
            S_CV:    qual_s = (ibat <= iend);
            S_END:   qual_s = (vbat < vrestart);
            default: qual_s = 1'b0;
        endcase
    end

    // Next-state logic; abort has priority over every other transition.
    always_comb begin
        state_d = state_q;
        if (abort_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_TC;
                end
                S_TC: begin
                    if (deb_hit_s) begin
                        state_d = S_CC;
                    end else begin
                        state_d = S_TC;
                    end
                end
                S_CC: begin
                    if (deb_hit_s) begin
                        state_d = S_CV;
                    end else begin
                        state_d = S_CC;
                    end
                end
                S_CV: begin
                    // Timer expiry and current qualification both lead to END.
                    if (deb_hit_s || tmr_exp_s) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_CV;
                    end
                end
                S_END: begin
                    if (deb_hit_s) begin
                        state_d = S_TC;
                    end else begin
                        state_d = S_END;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Debounce counter: cleared on any state change (the coincident sample
    // is dropped), otherwise counts qualifying samples and saturates at DEB.
    always_comb begin
        deb_d = deb_q;
        if (state_chg_s) begin
            deb_d = {CW{1'b0}};
        end else if (smpl) begin
            if (qual_s) begin
                if (deb_q < DEB_C) begin
                    deb_d = deb_q + CNT_ONE;
                end else begin
                    deb_d = deb_q;
                end
            end else begin
                deb_d = {CW{1'b0}};
            end
        end else begin
            deb_d = deb_q;
        end
    end

    // CV safety timer: zero outside CV and on entry, saturating count while in CV.
    always_comb begin
        tmr_d = tmr_q;
        if ((state_q == S_CV) && (state_d == S_CV)) begin
            if (tmr_q == TMR_MAX) begin
                tmr_d = tmr_q;
            end else begin
                tmr_d = tmr_q + TMR_ONE;
            end
        end else begin
            tmr_d = {TW{1'b0}};
        end
    end

    // Output decode from the next state so registered outputs track state_q.
    always_comb begin
        tc_d   = 1'b0;
        cc_d   = 1'b0;
        cv_d   = 1'b0;
        done_d = 1'b0;
        st_d   = state_d;
        case (state_d)
            S_TC:    tc_d   = 1'b1;
            S_CC:    cc_d   = 1'b1;
            S_CV:    cv_d   = 1'b1;
            S_END:   done_d = 1'b1;
            default: begin
                tc_d   = 1'b0;
                cc_d   = 1'b0;
                cv_d   = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // State, debounce, timer and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= S_IDLE;
            deb_q   <= {CW{1'b0}};
            tmr_q   <= {TW{1'b0}};
            tc_q    <= 1'b0;
            cc_q    <= 1'b0;
            cv_q    <= 1'b0;
            done_q  <= 1'b0;
            st_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            tmr_q   <= tmr_d;
            tc_q    <= tc_d;
            cc_q    <= cc_d;
            cv_q    <= cv_d;
            done_q  <= done_d;
            st_q    <= st_d;
        end
    end

    assign tc   = tc_q;
    assign cc   = cc_q;
    assign cv   = cv_q;
    assign done = done_q;
    assign st   = st_q;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// -----------------------------------------------------------------------------
// tb_batcharger_ctrl
// Directed scenarios with literal expectations followed by randomized stimulus,
// all checked every cycle against a mode/count/elapsed-time model of the charger.
// -----------------------------------------------------------------------------
module tb_batcharger_ctrl;

    localparam int W   = 8;
    localparam int DEB = 4;
    localparam int TW  = 16;

    localparam logic [6:0] O_IDLE = 7'b0000_000;
    localparam logic [6:0] O_TC   = 7'b1000_001;
    localparam logic [6:0] O_CC   = 7'b0100_010;
    localparam logic [6:0] O_CV   = 7'b0010_011;
    localparam logic [6:0] O_END  = 7'b0001_100;

    logic          clk = 1'b0;
    logic          rstz, en, vtok, smpl;
    logic [W-1:0]  vbat, ibat, vcutoff, vpreset, iend, vrestart;
    logic [TW-1:0] tmax;
    logic          tc, cc, cv, done;
    logic [2:0]    st;
    logic [6:0]    outs_s;

    int   vectors = 0;
    int   errors  = 0;
    logic chk_on  = 1'b0;

    always #5 clk = ~clk;

    assign outs_s = {tc, cc, cv, done, st};

    batcharger_ctrl #(.W(W), .DEB(DEB), .TW(TW)) dut (
        .clk(clk), .rstz(rstz), .en(en), .vtok(vtok), .smpl(smpl),
        .vbat(vbat), .ibat(ibat), .vcutoff(vcutoff), .vpreset(vpreset),
        .iend(iend), .vrestart(vrestart), .tmax(tmax),
        .tc(tc), .cc(cc), .cv(cv), .done(done), .st(st)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 trickle, 2 const-current, 3 const-voltage, 4 end
    int m_mode = 0;
    int m_cnt  = 0;   // consecutive qualifying samples in current mode
    int m_tmr  = 0;   // cycles already spent in CV

    function automatic bit qualifies(input int m);
        case (m)
            1:       return vbat >= vcutoff;
            2:       return vbat >= vpreset;
            3:       return ibat <= iend;
            4:       return vbat < vrestart;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [6:0] expected(input int m);
        logic [2:0] code;
        code = 3'(m);
        return {m == 1, m == 2, m == 3, m == 4, code};
    endfunction

    // Model update on every clock edge, with asynchronous reset.
    always @(posedge clk or negedge rstz) begin : model
        int nm, nc, nt;
        bit q, fire, expire;
        if (!rstz) begin
            m_mode <= 0;
            m_cnt  <= 0;
            m_tmr  <= 0;
        end else begin
            nm = m_mode; nc = m_cnt; nt = m_tmr;
            if (!en || !vtok) begin
                nm = 0; nc = 0; nt = 0;
            end else if (m_mode == 0) begin
                nm = 1; nc = 0; nt = 0;
            end else begin
                q      = smpl && qualifies(m_mode);
                fire   = q && (m_cnt + 1 >= DEB);
                expire = (m_mode == 3) && (tmax != 0) && (m_tmr + 1 == int'(tmax));
                if (fire || expire) begin
                    nm = (m_mode == 4) ? 1 : m_mode + 1;
                    nc = 0; nt = 0;
                end else begin
                    if (smpl) nc = q ? ((m_cnt + 1 > DEB) ? DEB : m_cnt + 1) : 0;
                    if (m_mode == 3) nt = (m_tmr >= 65535) ? 65535 : m_tmr + 1;
                end
            end
            m_mode <= nm;
            m_cnt  <= nc;
            m_tmr  <= nt;
        end
    end

    // Every-cycle comparison of the DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) check("cycle_outputs", 32'(outs_s), 32'(expected(m_mode)));
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe(input logic [7:0] v, input logic [7:0] i);
        vbat = v; ibat = i; smpl = 1'b1;
        @(negedge clk);
        smpl = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Four spaced samples; outputs are inspected right after the last strobe cycle.
    task automatic four(input logic [7:0] v, input logic [7:0] i);
        for (int k = 0; k < 4; k++) begin
            strobe(v, i);
            if (k < 3) gap(9);
        end
    endtask

    logic [7:0] seq1 [7] = '{8'h61, 8'h61, 8'h61, 8'h5F, 8'h61, 8'h61, 8'h61};

    initial begin
        int n;
        rstz = 1'b0; en = 1'b0; vtok = 1'b0; smpl = 1'b0;
        vbat = 8'h00; ibat = 8'hFF;
        vcutoff = 8'h60; vpreset = 8'hC0; iend = 8'h10; vrestart = 8'h80;
        tmax = 16'd0;
        gap(3);
        check("reset_outputs", 32'(outs_s), 32'(O_IDLE));
        chk_on = 1'b1;
        rstz = 1'b1;
        @(negedge clk);
        check("idle_disabled", 32'(outs_s), 32'(O_IDLE));
        en = 1'b1; vtok = 1'b1;
        @(negedge clk);
        check("start_tc", 32'(outs_s), 32'(O_TC));

        // TC with a non-qualifying sample breaking the run
        for (int k = 0; k < 7; k++) begin
            strobe(seq1[k], 8'hFF);
            gap(9);
        end
        check("tc_debounce_reset", 32'(outs_s), 32'(O_TC));
        strobe(8'h61, 8'hFF);
        check("tc_to_cc", 32'(outs_s), 32'(O_CC));
        gap(9);

        // CC -> CV -> END
        four(8'hC0, 8'hFF);
        check("cc_to_cv", 32'(outs_s), 32'(O_CV));
        gap(9);
        four(8'hC0, 8'h0F);
        check("cv_to_end", 32'(outs_s), 32'(O_END));
        gap(9);

        // END -> TC recharge
        four(8'h70, 8'hFF);
        check("end_to_tc", 32'(outs_s), 32'(O_TC));
        gap(9);

        // CV timer with tmax=100, current never qualifying
        tmax = 16'd100;
        four(8'h61, 8'h80);
        check("tc_to_cc_2", 32'(outs_s), 32'(O_CC));
        gap(9);
        four(8'hC0, 8'h80);
        check("cc_to_cv_2", 32'(outs_s), 32'(O_CV));
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("cv_timer_cycles", 32'(n), 32'd100);
        check("timer_end_state", 32'(outs_s), 32'(O_END));
        gap(9);

        // tmax=0 keeps CV indefinitely
        tmax = 16'd0;
        four(8'h70, 8'h80);
        gap(9);
        four(8'h61, 8'h80);
        gap(9);
        four(8'hC0, 8'h80);
        check("cc_to_cv_3", 32'(outs_s), 32'(O_CV));
        gap(300);
        check("cv_no_timer", 32'(outs_s), 32'(O_CV));

        // One-cycle vtok drop aborts to IDLE, then restarts in TC
        vtok = 1'b0;
        @(negedge clk);
        check("vtok_abort", 32'(outs_s), 32'(O_IDLE));
        vtok = 1'b1;
        @(negedge clk);
        check("vtok_restart", 32'(outs_s), 32'(O_TC));
        gap(9);

        // Asynchronous reset in CC clears outputs without a clock edge
        four(8'h61, 8'hFF);
        check("tc_to_cc_3", 32'(outs_s), 32'(O_CC));
        #2 rstz = 1'b0;
        #1 check("async_reset", 32'(outs_s), 32'(O_IDLE));
        @(negedge clk);
        rstz = 1'b1;
        @(negedge clk);
        check("post_reset_tc", 32'(outs_s), 32'(O_TC));

        // Randomized stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                vcutoff  = 8'($urandom);
                vpreset  = 8'($urandom);
                iend     = 8'($urandom);
                vrestart = 8'($urandom);
                tmax     = 16'($urandom_range(0, 60));
            end
            rstz = ($urandom_range(0, 999) != 0);
            en   = ($urandom_range(0, 299) != 0);
            vtok = ($urandom_range(0, 299) != 0);
            smpl = ($urandom_range(0, 2) == 0);
            vbat = 8'($urandom);
            ibat = 8'($urandom);
            @(negedge clk);
        end
        rstz = 1'b1; smpl = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
